div_result_writeback: RTL

- Sequential wrapper directly downstream of the combinational 64/32 signed divider.
- Registers operands into the divider and waits a fixed settle time for its deep combinational path.
- Captures the divider's sign-magnitude quotient/remainder, converts them to two's complement and flags divide-by-zero/overflow.
- Presents HI (remainder) / LO (quotient) to the register-file writeback through a valid/ready handshake.

---
 rtl/div_result_writeback_pkg.sv | 27 ++
 rtl/div_result_writeback_if.sv | 27 ++
 rtl/div_result_writeback_sm_to_tc64.sv | 13 +
 rtl/div_result_writeback.sv | 115 +++++++++++
 4 files changed

// File: rtl/div_result_writeback_pkg.sv
// Shared types and constants for the divider result writeback stage.
package div_result_writeback_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Operands the divider's magnitude path cannot represent
    localparam logic [63:0] A_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] B_MIN = 32'h8000_0000;

    // Quotient reported on divide-by-zero
    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

    // Range of a quotient that fits a 32-bit register
    localparam logic signed [63:0] Q_MAX = 64'sd2147483647;
    localparam logic signed [63:0] Q_MIN = -64'sd2147483648;

    // True when a 64-bit two's complement quotient does not fit in 32 bits
    function automatic logic quot_out_of_range(input logic [63:0] q);
        return ($signed(q) > Q_MAX) || ($signed(q) < Q_MIN);
    endfunction

endpackage

// File: rtl/div_result_writeback_if.sv
// Request/result bundle between the issuing logic, this stage and writeback.
interface div_result_writeback_if;

    logic        start;
    logic [63:0] a;
    logic [31:0] b;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ovf;

    // Seen from the writeback stage itself
    modport slave (
        input  start, a, b, res_ready,
        output busy, res_valid, hi, lo, dz, ovf
    );

    // Seen from the requester / register-file side
    modport master (
        output start, a, b, res_ready,
        input  busy, res_valid, hi, lo, dz, ovf
    );

endinterface

// File: rtl/div_result_writeback_sm_to_tc64.sv
// Sign-magnitude to two's complement conversion, 64-bit, combinational.
module sm_to_tc64 (
    input  logic [63:0] sm,
    output logic [63:0] tc
);

    logic [63:0] mag;

    // Negating a zero magnitude yields zero, so negative zero collapses to 0
    assign mag = {1'b0, sm[62:0]};
    assign tc  = sm[63] ? (~mag + 64'd1) : mag;

endmodule

// File: rtl/div_result_writeback.sv
// Sequential wrapper around the combinational 64/32 divider: registers the
// operands, waits for the deep path to settle, converts and flags the
// result, and offers HI/LO to writeback through a valid/ready handshake.
module div_result_writeback
    import div_result_writeback_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    div_result_writeback_if.slave       bus,
    output logic [63:0]                 div_a,
    output logic [31:0]                 div_b,
    input  logic [63:0]                 div_shang,
    input  logic [63:0]                 div_yu
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  counter;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        dz_flag;
    logic        ovf_flag;
    logic        valid_flag;
    logic [63:0] q64;
    logic [63:0] r64;

    sm_to_tc64 quot_conv (
        .sm (div_shang),
        .tc (q64)
    );

    sm_to_tc64 rem_conv (
        .sm (div_yu),
        .tc (r64)
    );

    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = valid_flag;
    assign bus.hi        = res_hi;
    assign bus.lo        = res_lo;
    assign bus.dz        = dz_flag;
    assign bus.ovf       = ovf_flag;

    // Control FSM; every output is registered here. The early-exit path
    // enters HOLD with res_valid low and raises it on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= 4'd0;
            div_a      <= 64'd0;
            div_b      <= 32'd0;
            res_hi     <= 32'd0;
            res_lo     <= 32'd0;
            dz_flag    <= 1'b0;
            ovf_flag   <= 1'b0;
            valid_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_a <= bus.a;
                        div_b <= bus.b;
                        if (bus.b == 32'd0) begin
                            state    <= HOLD;
                            dz_flag  <= 1'b1;
                            ovf_flag <= 1'b0;
                            res_lo   <= DZ_QUOT;
                            res_hi   <= bus.a[31:0];
                        end else if ((bus.a == A_MIN) || (bus.b == B_MIN)) begin
                            state    <= HOLD;
                            dz_flag  <= 1'b0;
                            ovf_flag <= 1'b1;
                            res_lo   <= 32'd0;
                            res_hi   <= 32'd0;
                        end else begin
                            state    <= WAIT;
                            counter  <= SETTLE_LOAD;
                            dz_flag  <= 1'b0;
                            ovf_flag <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (counter == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                CAPTURE: begin
                    res_lo     <= q64[31:0];
                    res_hi     <= r64[31:0];
                    ovf_flag   <= quot_out_of_range(q64);
                    valid_flag <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (!valid_flag) begin
                        valid_flag <= 1'b1;
                    end else if (bus.res_ready) begin
                        valid_flag <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
